jt12_kon_multi: RTL and testbench

Parametrised key-on tracker for the FM operator pipeline. It holds one key-on bit per slot, where a slot is a channel/operator pair, and presents the effective key-on of the current slot to the envelope generator each enabled cycle. Channel count is configurable for the 3-channel and 6-channel chip variants. Compared with the fixed 6-channel tracker it adds key-on/key-off edge outputs and latched CSM handling, so no timer-A overflow is lost whichever slot is current.

---
 rtl/jt12_kon_multi_if.sv | 43 ++++
 rtl/jt12_kon_multi.sv | 114 +++++++++++
 tb/tb_jt12_kon_multi.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_kon_multi_if.sv
// Bus bundle for the key-on tracker.
//
// Signal semantics: there is no valid/ready handshake on this bus. clk_en is
// the only qualifier and every input is sampled on a clk edge where clk_en=1.
// up_keyon is a level strobe: while it is high, each enabled slot whose
// channel equals keyon_ch takes its new key-on bit from keyon_op. The outputs
// are registered and change only on enabled edges.
//
// Signals:
//   clk_en      pipeline advance enable
//   cur_ch      channel of the slot presented this cycle
//   cur_op      operator of the slot presented this cycle (pipeline order)
//   keyon_ch    channel addressed by the key-on register write
//   keyon_op    operator mask of the write (bit0=S1 .. bit3=S4)
//   up_keyon    key-on register write strobe
//   csm         CSM mode enable
//   overflow_A  timer-A overflow pulse
//   keyon_I     effective key-on of the current slot
//   kon_edge    current slot went off->on versus its previous round
//   koff_edge   current slot went on->off versus its previous round
interface jt12_kon_multi_if;
    logic       clk_en;
    logic [2:0] cur_ch;
    logic [1:0] cur_op;
    logic [2:0] keyon_ch;
    logic [3:0] keyon_op;
    logic       up_keyon;
    logic       csm;
    logic       overflow_A;
    logic       keyon_I;
    logic       kon_edge;
    logic       koff_edge;

    modport slave (
        input  clk_en, cur_ch, cur_op, keyon_ch, keyon_op, up_keyon, csm, overflow_A,
        output keyon_I, kon_edge, koff_edge
    );

    modport master (
        output clk_en, cur_ch, cur_op, keyon_ch, keyon_op, up_keyon, csm, overflow_A,
        input  keyon_I, kon_edge, koff_edge
    );
endinterface

// File: rtl/jt12_kon_multi.sv
// Parametrised key-on tracker for the FM operator pipeline.
//
// Keeps one register key-on bit per slot (channel/operator pair) in a ring
// that rotates once per enabled cycle, so the ring head is always the slot
// currently presented. A second ring remembers the effective key-on emitted
// for each slot on its previous round, which yields the key-on/key-off edge
// outputs. CSM key-ons from timer-A overflow are latched in four pending bits
// (one per operator of channel CSM_CH) so an overflow is never lost no matter
// which slot is current when it arrives.
//
// Parameters:
//   NCH     number of channels (3 or 6); ring depth S = 4*NCH
//   CSM_CH  channel keyed by CSM on timer-A overflow (< NCH)
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   jt12_kon_multi_if.slave (inputs and registered outputs)
module jt12_kon_multi #(
    parameter int NCH    = 6,
    parameter int CSM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    jt12_kon_multi_if.slave   bus
);

    localparam int         S     = 4 * NCH;
    localparam logic [3:0] NCH_W = 4'(NCH);
    localparam logic [2:0] CSM_W = 3'(CSM_CH);

    logic [S-1:0] k_q, k_d;     // register key-on ring, bit 0 = current slot
    logic [S-1:0] e_q, e_d;     // effective key-on emitted last round
    logic [3:0]   pend_q, pend_d;
    logic         keyon_q, kon_q, koff_q;

    logic [3:0]   op_hot;
    logic         ch_valid;
    logic         wr_hit;
    logic         k_old;
    logic         k_new;
    logic         ovf_now;
    logic         csm_slot;
    logic         csm_hit;
    logic         eff;

    always_comb begin
        // cur_op is in pipeline order (S1,S3,S2,S4); map it onto the
        // register mask order (S1,S2,S3,S4).
        op_hot = 4'b0000;
        case (bus.cur_op)
            2'd0:    op_hot = 4'b0001;
            2'd1:    op_hot = 4'b0100;
            2'd2:    op_hot = 4'b0010;
            default: op_hot = 4'b1000;
        endcase

        // A write to a channel that does not exist in this variant must not
        // alias onto an (unused) invalid slot.
        ch_valid = ({1'b0, bus.keyon_ch} < NCH_W);
        wr_hit   = bus.up_keyon && ch_valid && (bus.keyon_ch == bus.cur_ch);

        k_old    = k_q[0];
        k_new    = wr_hit ? |(bus.keyon_op & op_hot) : k_old;

        ovf_now  = bus.csm && bus.overflow_A;
        csm_slot = (bus.cur_ch == CSM_W);
        // An overflow on the very enable its slot is current is consumed
        // directly instead of going through the pending bit.
        csm_hit  = csm_slot && (pend_q[bus.cur_op] || ovf_now);

        // The register write only affects the slot's next round; this round
        // still reports the stored value.
        eff      = k_old || csm_hit;

        k_d      = {k_new, k_q[S-1:1]};
        e_d      = {eff, e_q[S-1:1]};

        pend_d   = pend_q;
        if (!bus.csm) begin
            pend_d = 4'b0000;
        end else begin
            if (bus.overflow_A) begin
                pend_d = 4'b1111;
            end
            if (csm_slot) begin
                pend_d[bus.cur_op] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            e_q     <= '0;
            pend_q  <= 4'b0000;
            keyon_q <= 1'b0;
            kon_q   <= 1'b0;
            koff_q  <= 1'b0;
        end else if (bus.clk_en) begin
            k_q     <= k_d;
            e_q     <= e_d;
            pend_q  <= pend_d;
            keyon_q <= eff;
            kon_q   <= eff & ~e_q[0];
            koff_q  <= ~eff & e_q[0];
        end
    end

    assign bus.keyon_I   = keyon_q;
    assign bus.kon_edge  = kon_q;
    assign bus.koff_edge = koff_q;

endmodule

// File: tb/tb_jt12_kon_multi.sv
// Self-checking bench for jt12_kon_multi: a 6-channel and a 3-channel
// instance run side by side on the same stimulus, each with its own slot
// sequence. A per-(channel,operator) reference model predicts every output
// on every cycle; a round-based table and hand sequences add fixed expectations.
module tb_jt12_kon_multi;

    localparam int CSM_CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jt12_kon_multi_if if6 ();
    jt12_kon_multi_if if3 ();

    jt12_kon_multi #(.NCH(6), .CSM_CH(CSM_CH)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (if6.slave)
    );

    jt12_kon_multi #(.NCH(3), .CSM_CH(CSM_CH)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cnt     = 0;    // enabled cycles since start; sets slot positions
    int last_p6 = 0;

    // Reference model, index 0 = NCH 6 instance, 1 = NCH 3 instance.
    logic mk [2][8][4];     // register key-on per channel/operator
    logic me [2][8][4];     // effective key-on emitted last round
    logic mp [2][4];        // CSM pending per pipeline operator
    logic ek [2];
    logic ekon [2];
    logic ekoff [2];

    // stimulus variables applied by step()
    logic       s_en, s_wr, s_csm, s_ovf;
    logic [2:0] s_wch;
    logic [3:0] s_wop;

    typedef struct {
        logic       wr;
        logic [2:0] wch;
        logic [3:0] wop;
        logic       csm;
        int         csm_end;    // csm is high only for slots below this index
        int         ovf_slot;   // slot index of the overflow pulse, -1 none
        int         chk_ch;     // channel whose four slots are checked
        logic [3:0] ki;         // expected keyon_I, bit = cur_op
        logic [3:0] kon;
        logic [3:0] koff;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mkv(logic wr, logic [2:0] wch, logic [3:0] wop, logic csm,
                                 int csm_end, int ovf_slot, int chk_ch,
                                 logic [3:0] ki, logic [3:0] kon, logic [3:0] koff);
        vec_t r;
        r.wr = wr; r.wch = wch; r.wop = wop; r.csm = csm; r.csm_end = csm_end;
        r.ovf_slot = ovf_slot; r.chk_ch = chk_ch; r.ki = ki; r.kon = kon; r.koff = koff;
        return r;
    endfunction

    task automatic check(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 8; c++) begin
                for (int o = 0; o < 4; o++) begin
                    mk[d][c][o] = 1'b0;
                    me[d][c][o] = 1'b0;
                end
            end
            for (int o = 0; o < 4; o++) mp[d][o] = 1'b0;
            ek[d] = 1'b0; ekon[d] = 1'b0; ekoff[d] = 1'b0;
        end
    endtask

    // Register mask bit addressed by a pipeline-order operator.
    function automatic int mask_bit(int op);
        case (op)
            0:       return 0;
            1:       return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic model_step(int d, int nch, int ch, int op);
        logic k_old;
        logic hit;
        logic eff;
        k_old = mk[d][ch][op];
        hit   = (ch == CSM_CH) && (mp[d][op] || (s_csm && s_ovf));
        eff   = k_old || hit;
        if (s_wr && (int'(s_wch) == ch) && (int'(s_wch) < nch))
            mk[d][ch][op] = s_wop[mask_bit(op)];
        ek[d]    = eff;
        ekon[d]  = eff && !me[d][ch][op];
        ekoff[d] = !eff && me[d][ch][op];
        me[d][ch][op] = eff;
        if (!s_csm) begin
            for (int o = 0; o < 4; o++) mp[d][o] = 1'b0;
        end else begin
            if (s_ovf) for (int o = 0; o < 4; o++) mp[d][o] = 1'b1;
            if (ch == CSM_CH) mp[d][op] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("n6 keyon_I",   if6.keyon_I,   ek[0]);
        check("n6 kon_edge",  if6.kon_edge,  ekon[0]);
        check("n6 koff_edge", if6.koff_edge, ekoff[0]);
        check("n3 keyon_I",   if3.keyon_I,   ek[1]);
        check("n3 kon_edge",  if3.kon_edge,  ekon[1]);
        check("n3 koff_edge", if3.koff_edge, ekoff[1]);
    endtask

    // ---------------- driver ----------------
    // Slot order: position p presents op = p / NCH, ch = p % NCH.
    task automatic step();
        int p6, p3;
        p6 = cnt % 24;
        p3 = cnt % 12;
        if6.cur_ch = 3'(p6 % 6); if6.cur_op = 2'(p6 / 6);
        if3.cur_ch = 3'(p3 % 3); if3.cur_op = 2'(p3 / 3);
        if6.clk_en = s_en;  if3.clk_en = s_en;
        if6.up_keyon = s_wr; if3.up_keyon = s_wr;
        if6.keyon_ch = s_wch; if3.keyon_ch = s_wch;
        if6.keyon_op = s_wop; if3.keyon_op = s_wop;
        if6.csm = s_csm; if3.csm = s_csm;
        if6.overflow_A = s_ovf; if3.overflow_A = s_ovf;
        if (s_en) begin
            model_step(0, 6, p6 % 6, p6 / 6);
            model_step(1, 3, p3 % 3, p3 / 3);
        end
        @(posedge clk);
        #1;
        if (s_en) begin
            last_p6 = p6;
            cnt++;
        end
        compare_all();
    endtask

    task automatic idle_inputs();
        s_en = 1'b1; s_wr = 1'b0; s_wch = 3'd0; s_wop = 4'd0; s_csm = 1'b0; s_ovf = 1'b0;
    endtask

    // ---------------- main ----------------
    initial begin
        // Round table for the 6-channel instance (24 enables per row).
        //            wr wch  wop      csm end ovf chk ki       kon      koff
        tbl[0]  = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[1]  = mkv(1, 3'd1, 4'b1111, 0, 24, -1, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[2]  = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 1, 4'b1111, 4'b1111, 4'b0000);
        tbl[3]  = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 1, 4'b1111, 4'b0000, 4'b0000);
        tbl[4]  = mkv(1, 3'd1, 4'b0000, 0, 24, -1, 1, 4'b1111, 4'b0000, 4'b0000);
        tbl[5]  = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 1, 4'b0000, 4'b0000, 4'b1111);
        tbl[6]  = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[7]  = mkv(1, 3'd0, 4'b0100, 0, 24, -1, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[8]  = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 0, 4'b0010, 4'b0010, 4'b0000);
        tbl[9]  = mkv(1, 3'd0, 4'b0000, 0, 24, -1, 0, 4'b0010, 4'b0000, 4'b0000);
        tbl[10] = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 0, 4'b0000, 4'b0000, 4'b0010);
        tbl[11] = mkv(0, 3'd0, 4'b0000, 1, 24,  4, 2, 4'b1110, 4'b1110, 4'b0000);
        tbl[12] = mkv(0, 3'd0, 4'b0000, 1, 24, -1, 2, 4'b0001, 4'b0001, 4'b1110);
        tbl[13] = mkv(0, 3'd0, 4'b0000, 1, 24, -1, 2, 4'b0000, 4'b0000, 4'b0001);
        tbl[14] = mkv(0, 3'd0, 4'b0000, 1, 24, -1, 2, 4'b0000, 4'b0000, 4'b0000);
        tbl[15] = mkv(0, 3'd0, 4'b0000, 1,  5,  4, 2, 4'b0000, 4'b0000, 4'b0000);
        tbl[16] = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 2, 4'b0000, 4'b0000, 4'b0000);
        tbl[17] = mkv(1, 3'd2, 4'b1111, 0, 24, -1, 2, 4'b0000, 4'b0000, 4'b0000);
        tbl[18] = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 2, 4'b1111, 4'b1111, 4'b0000);
        tbl[19] = mkv(0, 3'd0, 4'b0000, 1, 24,  4, 2, 4'b1111, 4'b0000, 4'b0000);
        tbl[20] = mkv(0, 3'd0, 4'b0000, 1, 24, -1, 2, 4'b1111, 4'b0000, 4'b0000);
        tbl[21] = mkv(0, 3'd0, 4'b0000, 1, 24, -1, 2, 4'b1111, 4'b0000, 4'b0000);
        tbl[22] = mkv(1, 3'd2, 4'b0000, 0, 24, -1, 2, 4'b1111, 4'b0000, 4'b0000);
        tbl[23] = mkv(0, 3'd0, 4'b0000, 0, 24, -1, 2, 4'b0000, 4'b0000, 4'b1111);

        // ---- reset ----
        model_clear();
        idle_inputs();
        s_en = 1'b0;
        if6.cur_ch = 3'd0; if6.cur_op = 2'd0; if3.cur_ch = 3'd0; if3.cur_op = 2'd0;
        if6.clk_en = 1'b0; if3.clk_en = 1'b0;
        if6.up_keyon = 1'b0; if3.up_keyon = 1'b0;
        if6.keyon_ch = 3'd0; if3.keyon_ch = 3'd0;
        if6.keyon_op = 4'd0; if3.keyon_op = 4'd0;
        if6.csm = 1'b0; if3.csm = 1'b0;
        if6.overflow_A = 1'b0; if3.overflow_A = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset n6 keyon_I",   if6.keyon_I,   1'b0);
        check("reset n6 kon_edge",  if6.kon_edge,  1'b0);
        check("reset n6 koff_edge", if6.koff_edge, 1'b0);
        check("reset n3 keyon_I",   if3.keyon_I,   1'b0);
        check("reset n3 kon_edge",  if3.kon_edge,  1'b0);
        check("reset n3 koff_edge", if3.koff_edge, 1'b0);
        rst = 1'b0;

        // ---- table rounds ----
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 24; i++) begin
                idle_inputs();
                s_wr  = tbl[r].wr;
                s_wch = tbl[r].wch;
                s_wop = tbl[r].wop;
                s_csm = tbl[r].csm && (i < tbl[r].csm_end);
                s_ovf = (i == tbl[r].ovf_slot);
                step();
                if ((last_p6 % 6) == tbl[r].chk_ch) begin
                    check($sformatf("tbl%0d slot%0d keyon_I", r, i),   if6.keyon_I,   tbl[r].ki[last_p6 / 6]);
                    check($sformatf("tbl%0d slot%0d kon_edge", r, i),  if6.kon_edge,  tbl[r].kon[last_p6 / 6]);
                    check($sformatf("tbl%0d slot%0d koff_edge", r, i), if6.koff_edge, tbl[r].koff[last_p6 / 6]);
                end
            end
        end

        // ---- NCH=3: single-enable write to ch0 op0 returns 12 enables later ----
        idle_inputs();
        s_wr = 1'b1; s_wch = 3'd0; s_wop = 4'b1111;
        step();
        check("n3 write enable old value", if3.keyon_I, 1'b0);
        idle_inputs();
        for (int i = 1; i < 12; i++) begin
            step();
            check($sformatf("n3 latency idle %0d keyon_I", i), if3.keyon_I, 1'b0);
            check($sformatf("n3 latency idle %0d kon_edge", i), if3.kon_edge, 1'b0);
        end
        step();
        check("n3 latency 12 keyon_I",  if3.keyon_I,  1'b1);
        check("n3 latency 12 kon_edge", if3.kon_edge, 1'b1);

        // ---- clk_en low holds everything ----
        idle_inputs();
        s_wr = 1'b1; s_wch = 3'd1; s_wop = 4'b1111;
        repeat (24) step();
        idle_inputs();
        repeat (30) step();
        for (int i = 0; i < 6; i++) begin
            s_en = 1'b0; s_wr = 1'b1; s_wch = 3'($urandom_range(0, 7));
            s_wop = 4'($urandom_range(0, 15)); s_csm = 1'b1; s_ovf = 1'b1;
            step();
        end

        // ---- reset mid-round while a slot is keyed ----
        idle_inputs();
        begin
            int guard;
            guard = 0;
            step();
            while (!ek[0] && guard < 24) begin
                step();
                guard++;
            end
            check("reset precondition keyed slot", if6.keyon_I, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("midreset n6 keyon_I",   if6.keyon_I,   1'b0);
        check("midreset n6 kon_edge",  if6.kon_edge,  1'b0);
        check("midreset n6 koff_edge", if6.koff_edge, 1'b0);
        check("midreset n3 keyon_I",   if3.keyon_I,   1'b0);
        check("midreset n3 kon_edge",  if3.kon_edge,  1'b0);
        check("midreset n3 koff_edge", if3.koff_edge, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            step();
            check("post reset n6 no edge", if6.kon_edge | if6.koff_edge, 1'b0);
            check("post reset n3 no edge", if3.kon_edge | if3.koff_edge, 1'b0);
        end

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 1200; i++) begin
            s_en  = ($urandom_range(0, 9) != 0);
            s_wr  = ($urandom_range(0, 3) == 0);
            s_wch = 3'($urandom_range(0, 7));
            s_wop = 4'($urandom_range(0, 15));
            s_csm = ($urandom_range(0, 7) != 0);
            s_ovf = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
